// File: rtl/axis_mux_arbiter_pkg.sv
// rtl/axis_mux_arbiter_pkg.sv - shared state encoding and grant constants for the packet arbiter
package axis_mux_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic [1:0] grant_none = 2'b00;
    localparam logic [1:0] grant_a_oh = 2'b01;
    localparam logic [1:0] grant_b_oh = 2'b10;

    // One-hot {B,A} grant for a given arbiter state; IDLE grants nobody.
    function automatic logic [1:0] grant_of(input state_t s);
        case (s)
            GNT_A:   return grant_a_oh;
            GNT_B:   return grant_b_oh;
            default: return grant_none;
        endcase
    endfunction

endpackage

// File: rtl/axis_mux_arbiter_if.sv
// rtl/axis_mux_arbiter_if.sv - two source streams plus the shared output stream
interface axis_mux_arbiter_if #(
    parameter int data_width = 16
) ();

    logic [data_width-1:0] a;
    logic                  tvalid_in_a;
    logic                  tlast_in_a;
    logic                  tready_out_a;

    logic [data_width-1:0] b;
    logic                  tvalid_in_b;
    logic                  tlast_in_b;
    logic                  tready_out_b;

    logic [data_width-1:0] o;
    logic                  tvalid_out;
    logic                  tlast_out;
    logic                  tready_in;

    // Arbiter side: consumes both sources, produces the merged stream.
    modport slave (
        input  a, tvalid_in_a, tlast_in_a,
        input  b, tvalid_in_b, tlast_in_b,
        input  tready_in,
        output tready_out_a, tready_out_b,
        output o, tvalid_out, tlast_out
    );

    // Environment side: drives the producers and the downstream ready.
    modport master (
        output a, tvalid_in_a, tlast_in_a,
        output b, tvalid_in_b, tlast_in_b,
        output tready_in,
        input  tready_out_a, tready_out_b,
        input  o, tvalid_out, tlast_out
    );

endinterface

// File: rtl/axis_out_reg.sv
// rtl/axis_out_reg.sv - single-entry registered output stage with valid/ready hold
module axis_out_reg #(
    parameter int data_width = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [data_width-1:0] in_data,
    input  logic                  tready_in,
    output logic                  free,
    output logic [data_width-1:0] o,
    output logic                  tvalid,
    output logic                  tlast
);

    // The slot can take a new beat when it is empty or being drained this cycle.
    assign free = !tvalid || tready_in;

    // Load on accept, clear valid once drained, otherwise hold everything stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o      <= '0;
            tvalid <= 1'b0;
            tlast  <= 1'b0;
        end else if (in_valid) begin
            o      <= in_data;
            tlast  <= in_last;
            tvalid <= 1'b1;
        end else if (tready_in) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_mux_arbiter.sv
// rtl/axis_mux_arbiter.sv - packet-level round-robin arbiter and 2:1 stream mux
module axis_mux_arbiter
    import axis_mux_arbiter_pkg::*;
#(
    parameter int data_width = 16,
    parameter int cnt_width  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    axis_mux_arbiter_if.slave    bus,
    output logic [1:0]           grant,
    output logic [cnt_width-1:0] pkt_cnt_a,
    output logic [cnt_width-1:0] pkt_cnt_b
);

    localparam logic [cnt_width-1:0] cnt_one = cnt_width'(1);

    state_t                state;
    state_t                next_state;
    logic                  last_grant_b;
    logic                  out_free;
    logic                  accept;
    logic                  sel_last;
    logic [data_width-1:0] sel_data;
    logic                  pkt_done;

    assign grant    = grant_of(state);
    assign pkt_done = accept && sel_last;

    // Arbitration and per-source handshake; only the granted source ever sees ready.
    always_comb begin
        next_state       = state;
        accept           = 1'b0;
        sel_data         = bus.a;
        sel_last         = bus.tlast_in_a;
        bus.tready_out_a = 1'b0;
        bus.tready_out_b = 1'b0;
        case (state)
            IDLE: begin
                if (bus.tvalid_in_a && bus.tvalid_in_b) begin
                    next_state = last_grant_b ? GNT_A : GNT_B;
                end else if (bus.tvalid_in_a) begin
                    next_state = GNT_A;
                end else if (bus.tvalid_in_b) begin
                    next_state = GNT_B;
                end
            end
            GNT_A: begin
                bus.tready_out_a = out_free;
                accept           = bus.tvalid_in_a && out_free;
                if (accept && bus.tlast_in_a) begin
                    next_state = IDLE;
                end
            end
            GNT_B: begin
                sel_data         = bus.b;
                sel_last         = bus.tlast_in_b;
                bus.tready_out_b = out_free;
                accept           = bus.tvalid_in_b && out_free;
                if (accept && bus.tlast_in_b) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register; last_grant_b starts set so A wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            last_grant_b <= 1'b1;
        end else begin
            state <= next_state;
            if (pkt_done) begin
                last_grant_b <= (state == GNT_B);
            end
        end
    end

    // Completed-packet counters bump when the tlast beat is accepted and wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt_a <= '0;
            pkt_cnt_b <= '0;
        end else if (pkt_done) begin
            if (state == GNT_A) begin
                pkt_cnt_a <= pkt_cnt_a + cnt_one;
            end else if (state == GNT_B) begin
                pkt_cnt_b <= pkt_cnt_b + cnt_one;
            end
        end
    end

    axis_out_reg #(
        .data_width (data_width)
    ) u_out_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (accept),
        .in_last   (sel_last),
        .in_data   (sel_data),
        .tready_in (bus.tready_in),
        .free      (out_free),
        .o         (bus.o),
        .tvalid    (bus.tvalid_out),
        .tlast     (bus.tlast_out)
    );

endmodule

// File: tb/tb_axis_mux_arbiter.sv
// tb/tb_axis_mux_arbiter.sv - scoreboard bench for the packet round-robin stream arbiter
module tb_axis_mux_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] grant;
    logic [7:0] pkt_cnt_a;
    logic [7:0] pkt_cnt_b;

    axis_mux_arbiter_if #(.data_width(16)) bus ();

    axis_mux_arbiter #(
        .data_width (16),
        .cnt_width  (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .grant     (grant),
        .pkt_cnt_a (pkt_cnt_a),
        .pkt_cnt_b (pkt_cnt_b)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [16:0] exp_q[$];

    logic        stalled = 1'b0;
    logic [15:0] hold_o = '0;
    logic        hold_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [15:0] base, input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({with_last && (i == n - 1), base + 16'(i)});
        end
    endtask

    // Present n beats from one source, each held until it is accepted.
    task automatic send(input bit src, input logic [15:0] base, input int n, input bit with_last);
        bit acc;
        int cyc;
        for (int i = 0; i < n; i++) begin
            if (src) begin
                bus.b           = base + 16'(i);
                bus.tlast_in_b  = with_last && (i == n - 1);
                bus.tvalid_in_b = 1'b1;
            end else begin
                bus.a           = base + 16'(i);
                bus.tlast_in_a  = with_last && (i == n - 1);
                bus.tvalid_in_a = 1'b1;
            end
            acc = 1'b0;
            cyc = 0;
            while (!acc && cyc < 200) begin
                @(negedge clk);
                acc = src ? (bus.tvalid_in_b && bus.tready_out_b)
                          : (bus.tvalid_in_a && bus.tready_out_a);
                @(posedge clk);
                #1;
                cyc++;
            end
            if (!acc) begin
                checks++;
                failures++;
                $display("FAIL send_timeout src=%0d beat=%0d actual=no_accept required=accept", src, i);
            end
        end
        if (src) begin
            bus.tvalid_in_b = 1'b0;
            bus.tlast_in_b  = 1'b0;
        end else begin
            bus.tvalid_in_a = 1'b0;
            bus.tlast_in_a  = 1'b0;
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Monitor: pop and compare every beat the consumer takes, and enforce hold while stalled.
    always @(negedge clk) begin
        if (!reset_n) begin
            stalled <= 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_valid", 32'(bus.tvalid_out), 32'h1);
                chk("hold_data", 32'(bus.o), 32'(hold_o));
                chk("hold_last", 32'(bus.tlast_out), 32'(hold_last));
            end
            if (bus.tvalid_out && bus.tready_in) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=0x%0h required=none", bus.o);
                end else begin
                    chk("beat_data", 32'(bus.o), 32'(exp_q[0][15:0]));
                    chk("beat_last", 32'(bus.tlast_out), 32'(exp_q[0][16]));
                    void'(exp_q.pop_front());
                end
            end
            stalled   <= bus.tvalid_out && !bus.tready_in;
            hold_o    <= bus.o;
            hold_last <= bus.tlast_out;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] base_a;
        logic [15:0] base_b;
        logic [1:0]  pat[4];
        int          w;

        bus.a = '0; bus.tvalid_in_a = 1'b1; bus.tlast_in_a = 1'b0;
        bus.b = '0; bus.tvalid_in_b = 1'b0; bus.tlast_in_b = 1'b0;
        bus.tready_in = 1'b1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o", 32'(bus.o), 32'h0);
        chk("rst_tvalid", 32'(bus.tvalid_out), 32'h0);
        chk("rst_tlast", 32'(bus.tlast_out), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_cnt_a", 32'(pkt_cnt_a), 32'h0);
        chk("rst_cnt_b", 32'(pkt_cnt_b), 32'h0);
        chk("rst_ready_a", 32'(bus.tready_out_a), 32'h0);
        bus.tvalid_in_a = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // A alone, 3-beat packet; grant appears one cycle after valid
        push(16'h0001, 3, 1'b1);
        fork
            send(1'b0, 16'h0001, 3, 1'b1);
            begin
                @(negedge clk);
                chk("t1_grant_idle", 32'(grant), 32'h0);
                @(negedge clk);
                chk("t1_grant_a", 32'(grant), 32'h1);
            end
        join
        chk("t1_cnt_a", 32'(pkt_cnt_a), 32'h1);
        drain();

        // A was served last, so a tie now goes to B first
        push(16'h0020, 2, 1'b1);
        push(16'h0010, 2, 1'b1);
        fork
            send(1'b0, 16'h0010, 2, 1'b1);
            send(1'b1, 16'h0020, 2, 1'b1);
        join
        chk("t2_cnt_a", 32'(pkt_cnt_a), 32'h2);
        chk("t2_cnt_b", 32'(pkt_cnt_b), 32'h1);
        drain();

        // From reset both ties resolve A then B, with one IDLE bubble between packets
        pulse_reset();
        chk("t3_cnt_a_clr", 32'(pkt_cnt_a), 32'h0);
        chk("t3_cnt_b_clr", 32'(pkt_cnt_b), 32'h0);
        for (int r = 0; r < 2; r++) begin
            base_a = 16'h0050 + 16'(r * 16);
            base_b = 16'h0060 + 16'(r * 16);
            push(base_a, 2, 1'b1);
            push(base_b, 2, 1'b1);
            fork
                begin
                    send(1'b0, base_a, 2, 1'b1);
                    @(negedge clk);
                    chk("t3_bubble", 32'(grant), 32'h0);
                    @(negedge clk);
                    chk("t3_grant_b", 32'(grant), 32'h2);
                end
                send(1'b1, base_b, 2, 1'b1);
            join
            drain();
        end
        chk("t3_cnt_a", 32'(pkt_cnt_a), 32'h2);
        chk("t3_cnt_b", 32'(pkt_cnt_b), 32'h2);

        // 4-beat B packet with downstream ready toggled 1,0,0,1
        pat[0] = 2'd1; pat[1] = 2'd0; pat[2] = 2'd0; pat[3] = 2'd1;
        push(16'h0030, 4, 1'b1);
        fork
            send(1'b1, 16'h0030, 4, 1'b1);
            begin
                w = 0;
                while (grant != 2'b10 && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                for (int k = 0; k < 4; k++) begin
                    @(posedge clk);
                    #1;
                    bus.tready_in = pat[k][0];
                end
                @(posedge clk);
                #1;
                bus.tready_in = 1'b1;
            end
            repeat (8) begin
                @(negedge clk);
                chk("t4_ready_a", 32'(bus.tready_out_a), 32'h0);
            end
        join
        bus.tready_in = 1'b1;
        chk("t4_cnt_b", 32'(pkt_cnt_b), 32'h3);
        drain();

        // Reset after beat 2 of a 4-beat A packet: only beat 1 ever reaches the output
        push(16'h0040, 1, 1'b0);
        send(1'b0, 16'h0040, 2, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("t5_tvalid", 32'(bus.tvalid_out), 32'h0);
        chk("t5_grant", 32'(grant), 32'h0);
        chk("t5_cnt_a", 32'(pkt_cnt_a), 32'h0);
        chk("t5_cnt_b", 32'(pkt_cnt_b), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        drain();

        // 256 single-beat A packets wrap the counter; stray tlast on idle B is ignored
        bus.tlast_in_b = 1'b1;
        for (int i = 0; i < 256; i++) begin
            push(16'(i), 1, 1'b1);
            send(1'b0, 16'(i), 1, 1'b1);
            if (i == 254) begin
                chk("t6_cnt_a_255", 32'(pkt_cnt_a), 32'hff);
                chk("t6_ready_b", 32'(bus.tready_out_b), 32'h0);
            end
        end
        chk("t6_cnt_a_wrap", 32'(pkt_cnt_a), 32'h0);
        chk("t6_cnt_b", 32'(pkt_cnt_b), 32'h0);
        bus.tlast_in_b = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
